// File: rtl/alu_sequencer_pkg.sv
// Shared instruction-set definitions for the 8-bit processor control unit:
// opcodes, sequencer states, instruction field positions and decode flags.
package alu_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_NOOP = 4'h0,
    OP_IN   = 4'h1,
    OP_OUT  = 4'h2,
    OP_MOV  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_NAND = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JN   = 4'hB,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_FETCH_IMM,
    ST_WAIT_IN,
    ST_HALT
  } state_e;

  // instruction byte layout: [7:4] opcode, [3:2] rd, [1:0] rs
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 4;
  localparam int RD_MSB = 3;
  localparam int RD_LSB = 2;
  localparam int RS_MSB = 1;
  localparam int RS_LSB = 0;

  typedef struct packed {
    logic uses_alu;
    logic writes_reg;
    logic sets_flags;
    logic is_jump;
    logic is_in;
    logic is_out;
    logic is_halt;
  } dec_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode classifier; codes C-E and NOOP produce all-zero flags.
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_IN:   dec.is_in = 1'b1;
      OP_OUT: begin
        dec.uses_alu = 1'b1;
        dec.is_out   = 1'b1;
      end
      OP_MOV: begin
        dec.uses_alu   = 1'b1;
        dec.writes_reg = 1'b1;
      end
      OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR: begin
        dec.uses_alu   = 1'b1;
        dec.writes_reg = 1'b1;
        dec.sets_flags = 1'b1;
      end
      OP_JMP, OP_JZ, OP_JN: dec.is_jump = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns the PC, the latched
// opcode, the Z/N flags and the register-file / ALU / port handshakes.
//
// state        | meaning
// FETCH        | request byte at pc, latch opcode and selects on instrValid
// DECODE       | classify opcode, selects already driving rd/rs
// EXECUTE      | aluOpCode = opcode; OUT strobes here and returns to FETCH
// WRITEBACK    | register write strobe, flag update for arithmetic ops
// FETCH_IMM    | fetch jump target byte, resolve taken/not taken
// WAIT_IN      | stall until inValid, then write port data to rd
// HALT         | parked until reset
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstN,
  output logic [ADDR_W-1:0] instrAddr,
  output logic              instrReq,
  input  logic [7:0]        instrData,
  input  logic              instrValid,
  output logic [3:0]        aluOpCode,
  input  logic              aluZ,
  input  logic              aluN,
  output logic [1:0]        regSelA,
  output logic [1:0]        regSelB,
  output logic [1:0]        regWriteSel,
  output logic              regWriteEn,
  output logic              wbSrcIn,
  input  logic              inValid,
  output logic              inAck,
  output logic              outStrobe,
  output logic              flagZ,
  output logic              flagN,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        op_q, op_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [1:0]        sel_a_q, sel_a_d;
  logic [1:0]        sel_b_q, sel_b_d;
  logic [1:0]        wr_sel_q, wr_sel_d;
  logic              wr_en_q, wr_en_d;
  logic              out_stb_q, out_stb_d;
  logic              req_q, req_d;
  logic              halted_q, halted_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  dec_t              dec;
  logic              jump_taken;
  logic              in_fire;

  alu_seq_decode u_decode (
    .opcode (op_q),
    .dec    (dec)
  );

  // The IN handshake must write in the very cycle inValid is seen, so it is
  // decoded from the current state rather than registered.
  assign in_fire = (state_q == ST_WAIT_IN) && inValid;

  always_comb begin
    jump_taken = 1'b0;
    case (op_q)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = flag_z_q;
      OP_JN:   jump_taken = flag_n_q;
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    alu_op_d  = alu_op_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    wr_sel_d  = wr_sel_q;
    wr_en_d   = 1'b0;
    out_stb_d = 1'b0;
    req_d     = req_q;
    halted_d  = halted_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    case (state_q)
      ST_FETCH: begin
        if (instrValid) begin
          op_d     = instrData[OP_MSB:OP_LSB];
          sel_a_d  = instrData[RD_MSB:RD_LSB];
          sel_b_d  = instrData[RS_MSB:RS_LSB];
          wr_sel_d = instrData[RD_MSB:RD_LSB];
          pc_d     = pc_q + ADDR_W'(1);
          req_d    = 1'b0;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.is_halt) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (dec.is_jump) begin
          req_d   = 1'b1;
          state_d = ST_FETCH_IMM;
        end else if (dec.is_in) begin
          state_d = ST_WAIT_IN;
        end else if (dec.uses_alu) begin
          alu_op_d  = op_q;
          out_stb_d = dec.is_out;
          state_d   = ST_EXECUTE;
        end else begin
          req_d   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXECUTE: begin
        if (dec.is_out) begin
          alu_op_d = OP_NOOP;
          req_d    = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          wr_en_d = dec.writes_reg;
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        if (dec.sets_flags) begin
          flag_z_d = aluZ;
          flag_n_d = aluN;
        end
        alu_op_d = OP_NOOP;
        req_d    = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_WAIT_IN: begin
        if (inValid) begin
          req_d   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH_IMM: begin
        if (instrValid) begin
          pc_d    = jump_taken ? ADDR_W'(instrData) : pc_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        alu_op_d = OP_NOOP;
        req_d    = 1'b1;
        state_d  = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      op_q      <= OP_NOOP;
      alu_op_q  <= OP_NOOP;
      sel_a_q   <= 2'd0;
      sel_b_q   <= 2'd0;
      wr_sel_q  <= 2'd0;
      wr_en_q   <= 1'b0;
      out_stb_q <= 1'b0;
      req_q     <= 1'b1;
      halted_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      alu_op_q  <= alu_op_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      wr_sel_q  <= wr_sel_d;
      wr_en_q   <= wr_en_d;
      out_stb_q <= out_stb_d;
      req_q     <= req_d;
      halted_q  <= halted_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
    end
  end

  assign instrAddr   = pc_q;
  assign instrReq    = req_q;
  assign aluOpCode   = alu_op_q;
  assign regSelA     = sel_a_q;
  assign regSelB     = sel_b_q;
  assign regWriteSel = wr_sel_q;
  assign regWriteEn  = wr_en_q | in_fire;
  assign wbSrcIn     = in_fire;
  assign inAck       = in_fire;
  assign outStrobe   = out_stb_q;
  assign flagZ       = flag_z_q;
  assign flagN       = flag_n_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: program memory model, strobe scoreboard and
// directed cycle checks. Inputs change at posedge+2, outputs sampled at negedge.
module tb_alu_sequencer;

  logic       clk;
  logic       rstN;
  logic [7:0] instrAddr;
  logic       instrReq;
  logic [7:0] instrData;
  logic       instrValid;
  logic [3:0] aluOpCode;
  logic       aluZ, aluN;
  logic [1:0] regSelA, regSelB, regWriteSel;
  logic       regWriteEn, wbSrcIn, inValid, inAck, outStrobe;
  logic       flagZ, flagN, halted;

  logic [7:0] mem [256];
  logic       mem_en;

  typedef struct packed {
    logic       is_out;
    logic [1:0] sel;
    logic       wbsrc;
    logic [3:0] op;
  } ev_t;
  ev_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int in_ack_cnt = 0;
  logic p_we = 1'b0;
  logic p_out = 1'b0;

  alu_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rstN(rstN), .instrAddr(instrAddr), .instrReq(instrReq),
    .instrData(instrData), .instrValid(instrValid), .aluOpCode(aluOpCode),
    .aluZ(aluZ), .aluN(aluN), .regSelA(regSelA), .regSelB(regSelB),
    .regWriteSel(regWriteSel), .regWriteEn(regWriteEn), .wbSrcIn(wbSrcIn),
    .inValid(inValid), .inAck(inAck), .outStrobe(outStrobe),
    .flagZ(flagZ), .flagN(flagN), .halted(halted)
  );

  assign instrData  = mem[instrAddr];
  assign instrValid = instrReq & mem_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every write/out strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (regWriteEn || outStrobe || inAck) begin
      check("strobe_excl", {28'd0, outStrobe & regWriteEn, inAck & ~regWriteEn,
                            p_we & regWriteEn, p_out & outStrobe}, 32'd0);
      if (sb.size() == 0) begin
        check("sb_extra", sb.size(), 1);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("sb_kind", outStrobe, e.is_out);
        check("sb_op", aluOpCode, e.op);
        if (e.is_out) begin
          check("sb_out_selb", regSelB, e.sel);
          check("sb_out_nowe", regWriteEn, 1'b0);
        end else begin
          check("sb_wr_sel", regWriteSel, e.sel);
          check("sb_wbsrc", wbSrcIn, e.wbsrc);
          check("sb_inack", inAck, e.wbsrc);
        end
      end
    end
    if (inAck) in_ack_cnt++;
    p_we  = regWriteEn;
    p_out = outStrobe;
  end

  task automatic do_reset();
    rstN    = 1'b0;
    inValid = 1'b0;
    mem_en  = 1'b1;
    aluZ    = 1'b0;
    aluN    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    sb.delete();
    in_ack_cnt = 0;
    repeat (2) @(posedge clk);
  endtask

  // release reset; returns at the negedge sampling cycle 1 (FETCH at RESET_PC)
  task automatic release_rst();
    @(posedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // reset values
    do_reset();
    @(negedge clk);
    check("rst_addr", instrAddr, 8'h00);
    check("rst_op", aluOpCode, 4'h0);
    check("rst_flags", {flagZ, flagN}, 2'b00);
    check("rst_strobes", {regWriteEn, inAck, outStrobe, halted, wbSrcIn}, 5'b0);
    check("rst_sels", {regSelA, regSelB, regWriteSel}, 6'b0);

    // ADD r1,r1 with aluZ=1
    mem[0] = 8'h45;
    aluZ = 1'b1;
    sb.push_back('{is_out: 1'b0, sel: 2'd1, wbsrc: 1'b0, op: 4'h4});
    release_rst();
    check("add_c1", {instrReq, instrAddr, aluOpCode}, {1'b1, 8'h00, 4'h0});
    @(negedge clk);
    check("add_c2_sel", {regSelA, regSelB}, 4'b0101);
    @(negedge clk);
    check("add_c3_op", aluOpCode, 4'h4);
    @(negedge clk);
    check("add_c4", {aluOpCode, regWriteEn, regWriteSel}, {4'h4, 1'b1, 2'd1});
    @(negedge clk);
    check("add_c5", {flagZ, flagN, instrReq, instrAddr, aluOpCode}, {2'b10, 1'b1, 8'h01, 4'h0});
    check("add_sb", sb.size(), 0);

    // JZ not taken
    do_reset();
    mem[0] = 8'hA0; mem[1] = 8'h10;
    release_rst();
    @(negedge clk);
    @(negedge clk);
    check("jz_nt_imm", {instrReq, instrAddr}, {1'b1, 8'h01});
    @(negedge clk);
    check("jz_nt_pc", instrAddr, 8'h02);

    // JZ taken after ADD sets flagZ
    do_reset();
    mem[0] = 8'h45; mem[1] = 8'hA0; mem[2] = 8'h10;
    aluZ = 1'b1;
    sb.push_back('{is_out: 1'b0, sel: 2'd1, wbsrc: 1'b0, op: 4'h4});
    release_rst();
    repeat (7) @(negedge clk);
    check("jz_t_pc", {flagZ, instrAddr}, {1'b1, 8'h10});
    check("jz_t_sb", sb.size(), 0);

    // JMP to 0xFF then wrap to 0x00
    do_reset();
    mem[0] = 8'h90; mem[1] = 8'hFF; mem[255] = 8'h00;
    release_rst();
    repeat (3) @(negedge clk);
    check("jmp_ff", instrAddr, 8'hFF);
    repeat (2) @(negedge clk);
    check("jmp_wrap", {instrReq, instrAddr}, {1'b1, 8'h00});

    // IN r2 with stall, flags set beforehand by ADD
    do_reset();
    mem[0] = 8'h45; mem[1] = 8'h18;
    aluZ = 1'b1; aluN = 1'b1;
    sb.push_back('{is_out: 1'b0, sel: 2'd1, wbsrc: 1'b0, op: 4'h4});
    sb.push_back('{is_out: 1'b0, sel: 2'd2, wbsrc: 1'b1, op: 4'h0});
    release_rst();
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("in_stall", {regWriteEn, inAck, outStrobe, wbSrcIn}, 4'b0);
      @(negedge clk);
    end
    aluZ = 1'b0; aluN = 1'b0;
    @(posedge clk);
    #2 inValid = 1'b1;
    @(negedge clk);
    check("in_fire", {regWriteEn, wbSrcIn, inAck, regWriteSel}, {3'b111, 2'd2});
    @(negedge clk);
    check("in_one", {regWriteEn, wbSrcIn, inAck}, 3'b000);
    repeat (3) @(negedge clk);
    check("in_count", in_ack_cnt, 1);
    check("in_flags", {flagZ, flagN, halted}, 3'b111);
    check("in_sb", sb.size(), 0);

    // OUT r3 then MOV r0,r1; MOV leaves flags alone
    do_reset();
    mem[0] = 8'h23; mem[1] = 8'h31;
    aluZ = 1'b1; aluN = 1'b1;
    sb.push_back('{is_out: 1'b1, sel: 2'd3, wbsrc: 1'b0, op: 4'h2});
    sb.push_back('{is_out: 1'b0, sel: 2'd0, wbsrc: 1'b0, op: 4'h3});
    release_rst();
    repeat (2) @(negedge clk);
    check("out_c3", {outStrobe, aluOpCode, regSelB, regWriteEn}, {1'b1, 4'h2, 2'd3, 1'b0});
    repeat (12) @(negedge clk);
    check("mov_flags", {flagZ, flagN}, 2'b00);
    check("mov_halt", halted, 1'b1);
    check("mov_sb", sb.size(), 0);

    // HALT holds for 20 cycles
    do_reset();
    release_rst();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("halt_hold", {halted, instrReq}, 2'b10);
      @(negedge clk);
    end

    // reset during WRITEBACK of ADD: no write, reset values
    do_reset();
    mem[0] = 8'h45;
    aluZ = 1'b1;
    release_rst();
    repeat (2) @(negedge clk);
    check("wb_pre_op", aluOpCode, 4'h4);
    @(posedge clk);
    #2 rstN = 1'b0;
    mem[0] = 8'hF0;
    @(negedge clk);
    check("wb_rst", {regWriteEn, inAck, outStrobe, aluOpCode, instrAddr, flagZ, flagN},
          {3'b000, 4'h0, 8'h00, 2'b00});
    release_rst();
    repeat (2) @(negedge clk);
    check("wb_rst_halt", {halted, flagZ}, 2'b10);

    // instrValid withheld 10 cycles in FETCH
    do_reset();
    mem_en = 1'b0;
    release_rst();
    for (int i = 0; i < 10; i++) begin
      check("stall_fetch", {instrReq, instrAddr, aluOpCode}, {1'b1, 8'h00, 4'h0});
      @(negedge clk);
    end
    @(posedge clk);
    #2 mem_en = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_halt", halted, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
